// File: rtl/ap_action_queue_if.sv
// Handshake bundle between header parser, lookup table and packet editor
// around the action-pointer queue.
interface ap_action_queue_if #(
   parameter int AP_WIDTH        = 16,
   parameter int ACTION_WIDTH    = 160,
   parameter int FIFO_DEPTH_BITS = 2
) ();
   logic [AP_WIDTH-1:0]        in_ap;
   logic                       in_ap_vld;
   logic                       in_ap_rdy;
   logic [AP_WIDTH-1:0]        ap;
   logic                       ap_vld;
   logic [ACTION_WIDTH-1:0]    action;
   logic                       action_vld;
   logic [ACTION_WIDTH-1:0]    out_action;
   logic                       out_action_vld;
   logic                       out_action_rdy;
   logic [FIFO_DEPTH_BITS:0]   fifo_count;
   logic [15:0]                spurious_count;

   modport slave (
      input  in_ap, in_ap_vld, action, action_vld, out_action_rdy,
      output in_ap_rdy, ap, ap_vld, out_action, out_action_vld, fifo_count, spurious_count
   );

   modport master (
      output in_ap, in_ap_vld, action, action_vld, out_action_rdy,
      input  in_ap_rdy, ap, ap_vld, out_action, out_action_vld, fifo_count, spurious_count
   );
endinterface

// File: rtl/ap_action_queue.sv
// Issues action-pointer lookups and queues the returned actions in a FWFT FIFO,
// admitting a request only while in-flight + queued leaves room in the FIFO.
module ap_action_queue #(
   parameter int AP_WIDTH        = 16,
   parameter int ACTION_WIDTH    = 160,
   parameter int FIFO_DEPTH      = 4,
   parameter int FIFO_DEPTH_BITS = $clog2(FIFO_DEPTH),
   parameter int WARMUP_CYCLES   = 8
) (
   input logic              clk,
   input logic              reset,
   ap_action_queue_if.slave bus
);
   localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam int CW = FIFO_DEPTH_BITS + 1;

   typedef enum logic {WARMUP, RUN} state_t;

   state_t                     state;
   logic [WW-1:0]              warm_cnt;
   logic [CW-1:0]              outstanding;
   logic [CW-1:0]              count;
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
   logic [ACTION_WIDTH-1:0]    mem [FIFO_DEPTH];
   logic [CW:0]                credits;
   logic                       acc, ret, spur, pop;

   // Credits cover both lookups in flight and entries already queued.
   assign credits       = {1'b0, outstanding} + {1'b0, count};
   assign bus.in_ap_rdy = (state == RUN) && (credits < (CW+1)'(FIFO_DEPTH));

   assign acc  = bus.in_ap_vld && bus.in_ap_rdy;
   assign ret  = bus.action_vld && (outstanding != '0);
   assign spur = bus.action_vld && (outstanding == '0);
   assign pop  = bus.out_action_vld && bus.out_action_rdy;

   assign bus.out_action_vld = (count != '0);
   assign bus.out_action     = mem[rd_ptr];
   assign bus.fifo_count     = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= WARMUP;
         warm_cnt           <= '0;
         bus.ap             <= '0;
         bus.ap_vld         <= 1'b0;
         outstanding        <= '0;
         count              <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         bus.spurious_count <= '0;
      end else begin
         case (state)
            WARMUP: begin
               warm_cnt <= warm_cnt + 1'b1;
               if (warm_cnt == WW'(WARMUP_CYCLES - 1)) state <= RUN;
            end
            default: state <= RUN;
         endcase

         bus.ap_vld <= acc;
         if (acc) bus.ap <= bus.in_ap;

         outstanding <= outstanding + CW'(acc) - CW'(ret);
         count       <= count + CW'(ret) - CW'(pop);
         if (ret) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;

         // Unsolicited returns are dropped and only counted.
         if (spur && bus.spurious_count != 16'hFFFF)
            bus.spurious_count <= bus.spurious_count + 16'd1;
      end
   end

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (ret) mem[wr_ptr] <= bus.action;
   end
endmodule
